// File: rtl/rvga_mem_arbiter.sv
// Arbitrates one unified memory port between instruction fetch (imem) and load/store (dmem),
// with a busy-cycle watchdog. Define RVGA_MEM_ARB_RR_EN for round-robin grant on contention.
module rvga_mem_arbiter #(
  parameter int unsigned TIMEOUT_W = 10
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        imem_r_v_i,
  input  logic [31:0] imem_addr_i,
  output logic [31:0] imem_data_o,
  output logic        imem_resp_v_o,
  input  logic        dmem_r_v_i,
  input  logic        dmem_w_v_i,
  input  logic [31:0] dmem_addr_i,
  input  logic [31:0] dmem_data_i,
  input  logic [3:0]  dmem_wmask_i,
  output logic [31:0] dmem_data_o,
  output logic        dmem_resp_v_o,
  output logic        mem_r_v_o,
  output logic        mem_w_v_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  output logic [3:0]  mem_wmask_o,
  input  logic [31:0] mem_data_i,
  input  logic        mem_resp_v_i,
  output logic        timeout_o
);

  typedef enum logic [1:0] {IDLE, IBUSY, DBUSY} state_e;

  localparam logic [31:0]          TIMEOUT_DATA = 32'hDEADBEEF;
  localparam logic [TIMEOUT_W-1:0] WD_MAX       = '1;

  state_e               state_q, state_d;
  logic                 mem_r_v_q, mem_r_v_d;
  logic                 mem_w_v_q, mem_w_v_d;
  logic [31:0]          mem_addr_q, mem_addr_d;
  logic [31:0]          mem_data_q, mem_data_d;
  logic [3:0]           mem_wmask_q, mem_wmask_d;
  logic [TIMEOUT_W-1:0] wd_cnt_q, wd_cnt_d;
  logic                 timeout_q, timeout_d;
`ifdef RVGA_MEM_ARB_RR_EN
  logic                 last_dmem_q, last_dmem_d;
`endif

  logic        busy;
  logic        done;
  logic        dmem_req;
  logic        grant_dmem;
  logic [31:0] resp_data;

  always_comb begin
    state_d     = state_q;
    mem_r_v_d   = mem_r_v_q;
    mem_w_v_d   = mem_w_v_q;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    mem_wmask_d = mem_wmask_q;
    wd_cnt_d    = wd_cnt_q;
    timeout_d   = timeout_q;
`ifdef RVGA_MEM_ARB_RR_EN
    last_dmem_d = last_dmem_q;
`endif

    busy     = (state_q != IDLE);
    // A response in the expiry cycle wins over the watchdog
    done     = busy && (mem_resp_v_i || (wd_cnt_q == WD_MAX));
    dmem_req = dmem_r_v_i | dmem_w_v_i;
`ifdef RVGA_MEM_ARB_RR_EN
    grant_dmem = dmem_req && (!imem_r_v_i || !last_dmem_q);
`else
    grant_dmem = dmem_req;
`endif

    resp_data     = mem_resp_v_i ? (mem_w_v_q ? '0 : mem_data_i) : TIMEOUT_DATA;
    imem_resp_v_o = done && (state_q == IBUSY);
    dmem_resp_v_o = done && (state_q == DBUSY);
    imem_data_o   = imem_resp_v_o ? resp_data : '0;
    dmem_data_o   = dmem_resp_v_o ? resp_data : '0;

    case (state_q)
      IDLE: begin
        if (grant_dmem) begin
          state_d     = DBUSY;
          mem_r_v_d   = !dmem_w_v_i;
          mem_w_v_d   = dmem_w_v_i;
          mem_addr_d  = dmem_addr_i;
          mem_data_d  = dmem_w_v_i ? dmem_data_i : '0;
          mem_wmask_d = dmem_w_v_i ? dmem_wmask_i : '0;
          wd_cnt_d    = '0;
`ifdef RVGA_MEM_ARB_RR_EN
          last_dmem_d = 1'b1;
`endif
        end else if (imem_r_v_i) begin
          state_d     = IBUSY;
          mem_r_v_d   = 1'b1;
          mem_w_v_d   = 1'b0;
          mem_addr_d  = imem_addr_i;
          mem_data_d  = '0;
          mem_wmask_d = '0;
          wd_cnt_d    = '0;
`ifdef RVGA_MEM_ARB_RR_EN
          last_dmem_d = 1'b0;
`endif
        end
      end
      default: begin
        if (done) begin
          state_d     = IDLE;
          mem_r_v_d   = 1'b0;
          mem_w_v_d   = 1'b0;
          mem_addr_d  = '0;
          mem_data_d  = '0;
          mem_wmask_d = '0;
          if (!mem_resp_v_i) timeout_d = 1'b1;
        end else begin
          wd_cnt_d = wd_cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      mem_r_v_q   <= 1'b0;
      mem_w_v_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      mem_wmask_q <= '0;
      wd_cnt_q    <= '0;
      timeout_q   <= 1'b0;
`ifdef RVGA_MEM_ARB_RR_EN
      last_dmem_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      mem_r_v_q   <= mem_r_v_d;
      mem_w_v_q   <= mem_w_v_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      mem_wmask_q <= mem_wmask_d;
      wd_cnt_q    <= wd_cnt_d;
      timeout_q   <= timeout_d;
`ifdef RVGA_MEM_ARB_RR_EN
      last_dmem_q <= last_dmem_d;
`endif
    end
  end

  assign mem_r_v_o   = mem_r_v_q;
  assign mem_w_v_o   = mem_w_v_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_data_o  = mem_data_q;
  assign mem_wmask_o = mem_wmask_q;
  assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_rvga_mem_arbiter.sv
// Self-checking bench for rvga_mem_arbiter: transaction-level model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_rvga_mem_arbiter;

  localparam int          TW       = 3;
  localparam int          WD_LIMIT = (1 << TW) - 1;
  localparam logic [31:0] DEAD     = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        imem_r_v_i = 1'b0;
  logic [31:0] imem_addr_i = '0;
  logic [31:0] imem_data_o;
  logic        imem_resp_v_o;
  logic        dmem_r_v_i = 1'b0;
  logic        dmem_w_v_i = 1'b0;
  logic [31:0] dmem_addr_i = '0;
  logic [31:0] dmem_data_i = '0;
  logic [3:0]  dmem_wmask_i = '0;
  logic [31:0] dmem_data_o;
  logic        dmem_resp_v_o;
  logic        mem_r_v_o;
  logic        mem_w_v_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic [3:0]  mem_wmask_o;
  logic [31:0] mem_data_i = '0;
  logic        mem_resp_v_i = 1'b0;
  logic        timeout_o;

  int n_checks = 0;
  int n_errors = 0;

  rvga_mem_arbiter #(.TIMEOUT_W(TW)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .imem_r_v_i(imem_r_v_i), .imem_addr_i(imem_addr_i),
    .imem_data_o(imem_data_o), .imem_resp_v_o(imem_resp_v_o),
    .dmem_r_v_i(dmem_r_v_i), .dmem_w_v_i(dmem_w_v_i),
    .dmem_addr_i(dmem_addr_i), .dmem_data_i(dmem_data_i),
    .dmem_wmask_i(dmem_wmask_i), .dmem_data_o(dmem_data_o),
    .dmem_resp_v_o(dmem_resp_v_o),
    .mem_r_v_o(mem_r_v_o), .mem_w_v_o(mem_w_v_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_wmask_o(mem_wmask_o), .mem_data_i(mem_data_i),
    .mem_resp_v_i(mem_resp_v_i), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: who owns the port, what was latched, how long it has waited
  int          m_owner = 0;   // 0 none, 1 imem, 2 dmem
  logic        m_w = 1'b0;
  logic [31:0] m_addr = '0, m_data = '0;
  logic [3:0]  m_mask = '0;
  int          m_age = 0;
  logic        m_to = 1'b0;
  logic        m_last_d = 1'b0;
  logic        i_done_ev = 1'b0, d_done_ev = 1'b0;

  always @(negedge clk) begin
    logic        busy, done, ir, dr, dreq, take_d;
    logic [31:0] rdata;
    if (rst_i) begin
      m_owner = 0; m_age = 0; m_to = 1'b0; m_last_d = 1'b0;
    end
    busy  = (m_owner != 0);
    done  = busy && (mem_resp_v_i || (m_age == WD_LIMIT));
    rdata = mem_resp_v_i ? (m_w ? 32'h0 : mem_data_i) : DEAD;
    ir    = done && (m_owner == 1);
    dr    = done && (m_owner == 2);
    chk("mem_r_v", {31'b0, mem_r_v_o}, {31'b0, busy && !m_w});
    chk("mem_w_v", {31'b0, mem_w_v_o}, {31'b0, busy && m_w});
    chk("mem_addr", mem_addr_o, busy ? m_addr : 32'h0);
    chk("mem_data", mem_data_o, (busy && m_w) ? m_data : 32'h0);
    chk("mem_wmask", {28'b0, mem_wmask_o}, {28'b0, (busy && m_w) ? m_mask : 4'h0});
    chk("imem_resp_v", {31'b0, imem_resp_v_o}, {31'b0, ir});
    chk("imem_data", imem_data_o, ir ? rdata : 32'h0);
    chk("dmem_resp_v", {31'b0, dmem_resp_v_o}, {31'b0, dr});
    chk("dmem_data", dmem_data_o, dr ? rdata : 32'h0);
    chk("timeout", {31'b0, timeout_o}, {31'b0, m_to});
    i_done_ev = ir;
    d_done_ev = dr;
    if (!rst_i) begin
      if (busy) begin
        if (done) begin
          if (!mem_resp_v_i) m_to = 1'b1;
          m_owner = 0;
        end else begin
          m_age++;
        end
      end else begin
        dreq = dmem_r_v_i || dmem_w_v_i;
`ifdef RVGA_MEM_ARB_RR_EN
        take_d = dreq && (!imem_r_v_i || !m_last_d);
`else
        take_d = dreq;
`endif
        if (take_d) begin
          m_owner = 2; m_w = dmem_w_v_i; m_addr = dmem_addr_i;
          m_data = dmem_data_i; m_mask = dmem_wmask_i; m_age = 0; m_last_d = 1'b1;
        end else if (imem_r_v_i) begin
          m_owner = 1; m_w = 1'b0; m_addr = imem_addr_i;
          m_data = '0; m_mask = '0; m_age = 0; m_last_d = 1'b0;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] first_addr, second_addr;
    int          kind;

    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    #2;
    chk("rst mem_r_v", {31'b0, mem_r_v_o}, 32'h0);
    chk("rst mem_addr", mem_addr_o, 32'h0);
    chk("rst timeout", {31'b0, timeout_o}, 32'h0);
    chk("rst imem_data", imem_data_o, 32'h0);

    // imem only, memory answers 3 cycles after the strobe
    cyc(); imem_r_v_i = 1'b1; imem_addr_i = 32'h100; #2;
    chk("i0 idle strobe", {31'b0, mem_r_v_o}, 32'h0);
    for (int k = 1; k <= 3; k++) begin
      cyc(); #2;
      chk("i0 strobe", {31'b0, mem_r_v_o}, 32'h1);
      chk("i0 addr", mem_addr_o, 32'h100);
      chk("i0 no resp", {31'b0, imem_resp_v_o}, 32'h0);
    end
    cyc(); mem_resp_v_i = 1'b1; mem_data_i = 32'h00500093; #2;
    chk("i0 strobe last", {31'b0, mem_r_v_o}, 32'h1);
    chk("i0 resp", {31'b0, imem_resp_v_o}, 32'h1);
    chk("i0 data", imem_data_o, 32'h00500093);
    chk("i0 dmem quiet", {31'b0, dmem_resp_v_o}, 32'h0);
    cyc(); imem_r_v_i = 1'b0; mem_resp_v_i = 1'b0; #2;
    chk("i0 strobe drop", {31'b0, mem_r_v_o}, 32'h0);
    chk("i0 pulse one", {31'b0, imem_resp_v_o}, 32'h0);

    // store, request dropped and inputs changed mid-flight
    cyc(); dmem_w_v_i = 1'b1; dmem_addr_i = 32'h3000; dmem_data_i = 32'hA5A5A5A5; dmem_wmask_i = 4'h3; #2;
    cyc(); #2;
    chk("st w_v", {31'b0, mem_w_v_o}, 32'h1);
    chk("st r_v", {31'b0, mem_r_v_o}, 32'h0);
    chk("st addr", mem_addr_o, 32'h3000);
    chk("st data", mem_data_o, 32'hA5A5A5A5);
    chk("st mask", {28'b0, mem_wmask_o}, 32'h3);
    cyc(); dmem_w_v_i = 1'b0; dmem_addr_i = 32'hFFFF; dmem_data_i = 32'h0; dmem_wmask_i = 4'h0; #2;
    chk("st addr held", mem_addr_o, 32'h3000);
    chk("st data held", mem_data_o, 32'hA5A5A5A5);
    cyc(); mem_resp_v_i = 1'b1; mem_data_i = 32'h12345678; #2;
    chk("st resp", {31'b0, dmem_resp_v_o}, 32'h1);
    chk("st resp data", dmem_data_o, 32'h0);
    chk("st imem quiet", {31'b0, imem_resp_v_o}, 32'h0);
    cyc(); mem_resp_v_i = 1'b0; #2;
    chk("st w drop", {31'b0, mem_w_v_o}, 32'h0);

    // simultaneous imem + dmem read
`ifdef RVGA_MEM_ARB_RR_EN
    first_addr = 32'h104; second_addr = 32'h2000;
`else
    first_addr = 32'h2000; second_addr = 32'h104;
`endif
    cyc(); imem_r_v_i = 1'b1; imem_addr_i = 32'h104; dmem_r_v_i = 1'b1; dmem_addr_i = 32'h2000; #2;
    cyc(); #2;
    chk("sim first addr", mem_addr_o, first_addr);
    cyc(); mem_resp_v_i = 1'b1; mem_data_i = 32'hCAFE0001; #2;
`ifdef RVGA_MEM_ARB_RR_EN
    chk("sim first resp", {31'b0, imem_resp_v_o}, 32'h1);
    chk("sim first data", imem_data_o, 32'hCAFE0001);
    chk("sim other quiet", {31'b0, dmem_resp_v_o}, 32'h0);
    cyc(); mem_resp_v_i = 1'b0; imem_r_v_i = 1'b0; #2;
`else
    chk("sim first resp", {31'b0, dmem_resp_v_o}, 32'h1);
    chk("sim first data", dmem_data_o, 32'hCAFE0001);
    chk("sim other quiet", {31'b0, imem_resp_v_o}, 32'h0);
    cyc(); mem_resp_v_i = 1'b0; dmem_r_v_i = 1'b0; #2;
`endif
    chk("sim dead cycle", {31'b0, mem_r_v_o}, 32'h0);
    cyc(); #2;
    chk("sim second strobe", {31'b0, mem_r_v_o}, 32'h1);
    chk("sim second addr", mem_addr_o, second_addr);
    cyc(); mem_resp_v_i = 1'b1; mem_data_i = 32'hCAFE0002; #2;
`ifdef RVGA_MEM_ARB_RR_EN
    chk("sim second data", dmem_data_o, 32'hCAFE0002);
`else
    chk("sim second data", imem_data_o, 32'hCAFE0002);
`endif
    cyc(); mem_resp_v_i = 1'b0; imem_r_v_i = 1'b0; dmem_r_v_i = 1'b0; #2;

    // watchdog: no response
    cyc(); imem_r_v_i = 1'b1; imem_addr_i = 32'h400; #2;
    for (int k = 1; k <= WD_LIMIT; k++) begin
      cyc(); #2;
      chk("wd waiting", {31'b0, imem_resp_v_o}, 32'h0);
      chk("wd flag low", {31'b0, timeout_o}, 32'h0);
    end
    cyc(); #2;
    chk("wd resp", {31'b0, imem_resp_v_o}, 32'h1);
    chk("wd data", imem_data_o, DEAD);
    cyc(); imem_r_v_i = 1'b0; #2;
    chk("wd flag set", {31'b0, timeout_o}, 32'h1);
    chk("wd strobe drop", {31'b0, mem_r_v_o}, 32'h0);
    cyc(); dmem_r_v_i = 1'b1; dmem_addr_i = 32'h500; #2;
    cyc(); #2;
    chk("wd next addr", mem_addr_o, 32'h500);
    cyc(); mem_resp_v_i = 1'b1; mem_data_i = 32'h0BADF00D; #2;
    chk("wd next data", dmem_data_o, 32'h0BADF00D);
    cyc(); mem_resp_v_i = 1'b0; dmem_r_v_i = 1'b0; #2;
    chk("wd flag sticky", {31'b0, timeout_o}, 32'h1);

    // spurious response in IDLE plus dual-strobe dmem request
    cyc(); mem_resp_v_i = 1'b1; mem_data_i = 32'h77777777;
    dmem_r_v_i = 1'b1; dmem_w_v_i = 1'b1; dmem_addr_i = 32'h600; dmem_data_i = 32'h11112222; dmem_wmask_i = 4'hF; #2;
    chk("sp no dresp", {31'b0, dmem_resp_v_o}, 32'h0);
    chk("sp no iresp", {31'b0, imem_resp_v_o}, 32'h0);
    cyc(); mem_resp_v_i = 1'b0; #2;
    chk("dual w_v", {31'b0, mem_w_v_o}, 32'h1);
    chk("dual r_v", {31'b0, mem_r_v_o}, 32'h0);
    chk("dual data", mem_data_o, 32'h11112222);
    cyc(); mem_resp_v_i = 1'b1; mem_data_i = 32'h33333333; #2;
    chk("dual resp data", dmem_data_o, 32'h0);
    cyc(); mem_resp_v_i = 1'b0; dmem_r_v_i = 1'b0; dmem_w_v_i = 1'b0; #2;

    // asynchronous reset two cycles into DBUSY
    cyc(); dmem_r_v_i = 1'b1; dmem_addr_i = 32'h700; #2;
    cyc(); #2;
    cyc(); #2;
    chk("ar busy", {31'b0, mem_r_v_o}, 32'h1);
    rst_i = 1'b1; dmem_r_v_i = 1'b0; mem_resp_v_i = 1'b1; mem_data_i = 32'h44444444;
    #1;
    chk("ar mem_r_v", {31'b0, mem_r_v_o}, 32'h0);
    chk("ar mem_addr", mem_addr_o, 32'h0);
    chk("ar dresp", {31'b0, dmem_resp_v_o}, 32'h0);
    chk("ar dmem_data", dmem_data_o, 32'h0);
    chk("ar timeout", {31'b0, timeout_o}, 32'h0);
    cyc(); rst_i = 1'b0; #2;
    chk("ar no resp after", {31'b0, dmem_resp_v_o}, 32'h0);
    cyc(); mem_resp_v_i = 1'b0; imem_r_v_i = 1'b1; imem_addr_i = 32'h800; #2;
    cyc(); #2;
    chk("ar next addr", mem_addr_o, 32'h800);
    // response lands exactly in the expiry cycle
    for (int k = 1; k < WD_LIMIT; k++) cyc();
    cyc(); mem_resp_v_i = 1'b1; mem_data_i = 32'h55555555; #2;
    chk("tie resp", {31'b0, imem_resp_v_o}, 32'h1);
    chk("tie data", imem_data_o, 32'h55555555);
    cyc(); mem_resp_v_i = 1'b0; imem_r_v_i = 1'b0; #2;
    chk("tie no timeout", {31'b0, timeout_o}, 32'h0);

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      cyc();
      if (i_done_ev) imem_r_v_i = 1'b0;
      else if (imem_r_v_i && ($urandom % 40 == 0)) imem_r_v_i = 1'b0;
      else if (!imem_r_v_i && ($urandom % 3 == 0)) begin
        imem_r_v_i = 1'b1; imem_addr_i = $urandom;
      end
      if (d_done_ev || ((dmem_r_v_i || dmem_w_v_i) && ($urandom % 40 == 0))) begin
        dmem_r_v_i = 1'b0; dmem_w_v_i = 1'b0;
      end else if (!dmem_r_v_i && !dmem_w_v_i && ($urandom % 3 == 0)) begin
        kind = $urandom_range(0, 2);
        dmem_r_v_i = (kind != 1); dmem_w_v_i = (kind != 0);
        dmem_addr_i = $urandom; dmem_data_i = $urandom; dmem_wmask_i = 4'($urandom);
      end
      mem_resp_v_i = ($urandom % 3 == 0);
      mem_data_i   = $urandom;
    end
    cyc();
    imem_r_v_i = 1'b0; dmem_r_v_i = 1'b0; dmem_w_v_i = 1'b0; mem_resp_v_i = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rvga_mem_arbiter.md
Name: rvga_mem_arbiter

Overview:
- Shares one unified memory port between the core's instruction-fetch port (imem) and load/store port (dmem).
- Sits between the pipeline top and the single external memory / L2 interface.
- Accepts one transaction at a time, holds it stable on the memory port until the memory responds, then routes the response back to the owning requester as a one-cycle pulse.
- Includes a watchdog that aborts transactions the memory never answers.

Parameters:
- TIMEOUT_W, 10: watchdog counter width. A transaction aborts after 2^TIMEOUT_W-1 busy cycles without a response.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- imem_r_v_i  in  1  instruction read request, held until imem_resp_v_o
- imem_addr_i  in  32  instruction address
- imem_data_o  out  32  instruction read data
- imem_resp_v_o  out  1  instruction response pulse
- dmem_r_v_i  in  1  data read request
- dmem_w_v_i  in  1  data write request
- dmem_addr_i  in  32  data address
- dmem_data_i  in  32  store data
- dmem_wmask_i  in  4  byte write mask
- dmem_data_o  out  32  load data
- dmem_resp_v_o  out  1  data response pulse
- mem_r_v_o  out  1  memory read strobe
- mem_w_v_o  out  1  memory write strobe
- mem_addr_o  out  32  memory address
- mem_data_o  out  32  memory write data
- mem_wmask_o  out  4  memory byte mask
- mem_data_i  in  32  memory read data
- mem_resp_v_i  in  1  memory response, one cycle
- timeout_o  out  1  sticky watchdog error flag

Behaviour:
- Clock and reset: one clock, clk_i; rst_i is asynchronous and active-high.
- Reset values: state IDLE; all mem_* outputs 0; both resp pulses 0; imem_data_o/dmem_data_o 0; timeout_o 0; watchdog count 0.
- Reset mid-transaction: the transaction is abandoned immediately and no response is pulsed.
- FSM states: IDLE, IBUSY, DBUSY.
- IDLE:
  - dmem request pending (r or w) -> DBUSY. dmem has priority because a dmem stall freezes the whole pipeline.
  - Otherwise, imem_r_v_i -> IBUSY.
  - Otherwise stay in IDLE.
- Grant latch: on the grant edge, addr/data/wmask/r/w are registered into the mem_* outputs and stay stable until the transaction ends.
- Write precedence: if dmem_r_v_i and dmem_w_v_i are both high, the transaction is a write.
- Read mask: mem_wmask_o = 0 and mem_data_o = 0 on reads.
- Latency:
  - Request seen in IDLE at cycle N -> mem strobe high from N+1.
  - mem_resp_v_i at cycle M -> owner resp pulse high in cycle M, combinational, with data = mem_data_i.
  - State returns to IDLE at M+1; mem strobes drop at M+1.
  - Next grant strobes no earlier than M+2, i.e. one dead cycle between transactions.
- Response in IDLE: mem_resp_v_i while in IDLE is ignored.
- Write responses: dmem_resp_v_o pulses with dmem_data_o = 0.
- Dropped request: if a requester drops its valid while its transaction is in flight, the transaction still completes and the response pulse is still issued.
- Non-owner: the non-owning requester's resp output stays 0 throughout.
- Watchdog:
  - Counts busy cycles and clears on entry to a BUSY state.
  - At count 2^TIMEOUT_W-1 with no response: set timeout_o, pulse the owner's resp with data 0xDEADBEEF, and return to IDLE.
  - A response arriving in the same cycle as the timeout wins: normal data is returned and timeout_o stays 0.
  - timeout_o clears only on reset.

Optional Feature:
- Macro RVGA_MEM_ARB_RR_EN.
- Defined: a last-grant register (reset value imem). When both requesters are pending in IDLE, grant the one not granted last. Single requests are granted as usual.
- Undefined: fixed dmem-over-imem priority; the last-grant register is not built.

Test Plan:
- Imem only: addr 0x100, memory responds 3 cycles after strobe with 0x00500093 -> mem_r_v_o high cycles N+1..N+4; imem_resp_v_o pulses one cycle with data 0x00500093; dmem_resp_v_o stays 0.
- Simultaneous: imem 0x104 and dmem read 0x2000 pending in the same cycle -> dmem served first. Without RR, imem strobes start 2 cycles after the dmem response. With RR, after a previous dmem grant, imem is served first.
- Store: dmem_w_v_i, addr 0x3000, data 0xA5A5A5A5, wmask 0x3 -> mem_w_v_o=1 with identical addr/data/mask held until response; dmem_resp_v_o pulses with data 0.
- Watchdog: TIMEOUT_W=3, no response -> after 7 busy cycles the owner pulse carries 0xDEADBEEF, timeout_o=1 and remains high; the next request is served normally.
- Async reset asserted 2 cycles into DBUSY -> all outputs 0 immediately (same cycle, no clock edge); no resp pulse after release; the subsequent imem request is granted normally.
- Spurious mem_resp_v_i in IDLE plus a dmem read with both r and w high -> spurious response ignored (no pulses); dual-strobe request issues mem_w_v_o=1, mem_r_v_o=0.
